// File: rtl/oled_char_writer.sv
// OLED character writer: renders one 8-column glyph from an external font ROM
// into the 4x128 page memory, or zero-fills the whole memory on a clear request.
module oled_char_writer #(
  parameter int FONT_LATENCY = 1,
  parameter int MEM_DEPTH    = 512,
  localparam int AW          = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_start,
  input  logic [7:0]    write_ascii_data,
  input  logic [AW-1:0] write_base_addr,
  output logic          write_ready,
  input  logic          clear_start,
  output logic [9:0]    font_addr,
  input  logic [7:0]    font_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata
);

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN, CLEAR} state_t;

  localparam logic [1:0]  DRAIN_LAST = 2'(FONT_LATENCY);
  localparam logic [AW:0] CLR_END    = (AW + 1)'(MEM_DEPTH);

  state_t        state, next_state;
  logic [6:0]    glyph;
  logic [1:0]    row;
  logic [6:0]    x;
  logic [2:0]    col;
  logic [1:0]    drain_cnt;
  logic [AW:0]   clr_cnt;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic          data_sel;
  logic          clear_active;

  assign clear_active = (state == CLEAR) && (clr_cnt != CLR_END);

  // ROM data is only forwarded on glyph writes; a clear writes zeros.
  assign mem_wdata = data_sel ? font_data : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (write_ready) begin
          if (clear_start)      next_state = CLEAR;
          else if (write_start) next_state = WRITE;
        end
      end
      WRITE:   if (col == 3'd7)              next_state = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST)  next_state = IDLE;
      CLEAR:   if (clr_cnt == CLR_END)       next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Two-stage pipeline: stage 1 issues the ROM address, stage 2 writes memory
  // in the cycle the ROM byte comes back.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_ready <= 1'b0;
      glyph       <= '0;
      row         <= '0;
      x           <= '0;
      col         <= '0;
      drain_cnt   <= '0;
      clr_cnt     <= '0;
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      font_addr   <= '0;
      data_sel    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
    end else begin
      write_ready <= (next_state == IDLE);
      issue_valid <= (state == WRITE);
      data_sel    <= issue_valid;
      mem_we      <= issue_valid || clear_active;

      if (issue_valid)       mem_addr <= issue_addr;
      else if (clear_active) mem_addr <= clr_cnt[AW-1:0];

      case (state)
        IDLE: begin
          if (next_state == WRITE) begin
            glyph <= write_ascii_data[7] ? 7'h7F : write_ascii_data[6:0];
            row   <= write_base_addr[AW-1:AW-2];
            x     <= write_base_addr[6:0];
            col   <= 3'd0;
          end
          if (next_state == CLEAR) clr_cnt <= '0;
        end
        WRITE: begin
          font_addr  <= {glyph, col};
          issue_addr <= {row, x + {4'b0000, col}};
          col        <= col + 3'd1;
          drain_cnt  <= 2'd0;
        end
        DRAIN: drain_cnt <= drain_cnt + 2'd1;
        CLEAR: if (clear_active) clr_cnt <= clr_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_char_writer.sv
// Self-checking bench for oled_char_writer: a font ROM model plus a scoreboard
// of expected (cycle, address, data) memory writes.
module tb_oled_char_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_start = 1'b0;
  logic [7:0] write_ascii_data = 8'h00;
  logic [8:0] write_base_addr = 9'h000;
  logic       write_ready;
  logic       clear_start = 1'b0;
  logic [9:0] font_addr;
  logic [7:0] font_data = 8'h00;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;

  typedef struct {
    int         cyc;
    logic [8:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  oled_char_writer #(.FONT_LATENCY(1), .MEM_DEPTH(512)) dut (
    .clk              (clk),
    .rst              (rst),
    .write_start      (write_start),
    .write_ascii_data (write_ascii_data),
    .write_base_addr  (write_base_addr),
    .write_ready      (write_ready),
    .clear_start      (clear_start),
    .font_addr        (font_addr),
    .font_data        (font_data),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Font ROM with one cycle of read latency; contents are a simple function of the address.
  always @(posedge clk) font_data <= {1'b0, font_addr[9:3] ^ {4'b0000, font_addr[2:0]}};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Every memory write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_we", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("we_cycle", cyc, e.cyc);
        checkOutput("we_addr", {23'd0, mem_addr}, {23'd0, e.addr});
        checkOutput("we_data", {24'd0, mem_wdata}, {24'd0, e.data});
      end
    end
  end

  task automatic waitReady(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (write_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("ready_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] ascii, input logic [8:0] base,
                               input bit busy_pulse, input bit mid_reset);
    int t;
    bit ok;
    logic [6:0] g;
    waitReady(50);
    t = cyc + 1;
    g = ascii[7] ? 7'h7F : ascii[6:0];
    for (int c = 0; c < 8; c++) begin
      exp_t e;
      e.cyc  = t + 2 + c;
      e.addr = {base[8:7], 7'(base[6:0] + c)};
      e.data = {1'b0, g ^ 7'(c)};
      if (!mid_reset || c < 3) sb.push_back(e);
    end
    write_ascii_data = ascii;
    write_base_addr  = base;
    write_start      = 1'b1;
    @(negedge clk);
    write_start      = 1'b0;
    write_ascii_data = 8'($urandom);
    write_base_addr  = 9'($urandom);
    checkOutput("ready_drop", {31'd0, write_ready}, 32'd0);
    if (mid_reset) begin
      for (int k = 0; k < 20 && cyc != t + 4; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_we_low", {31'd0, mem_we}, 32'd0);
      checkOutput("rst_ready_low", {31'd0, write_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready_back", {31'd0, write_ready}, 32'd1);
      checkOutput("rst_sb_empty", sb.size(), 32'd0);
      return;
    end
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      write_start = busy_pulse && (cyc == t + 3);
      if (write_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    write_start = 1'b0;
    checkOutput("write_timeout", {31'd0, ok}, 32'd1);
    checkOutput("write_latency", cyc, t + 10);
    checkOutput("write_sb_empty", sb.size(), 32'd0);
  endtask

  task automatic applyClear();
    int t;
    waitReady(50);
    t = cyc + 1;
    for (int i = 0; i < 512; i++) begin
      exp_t e;
      e.cyc  = t + 1 + i;
      e.addr = 9'(i);
      e.data = 8'h00;
      sb.push_back(e);
    end
    clear_start      = 1'b1;
    write_start      = 1'b1;
    write_ascii_data = 8'h41;
    write_base_addr  = 9'h000;
    @(negedge clk);
    clear_start = 1'b0;
    write_start = 1'b0;
    checkOutput("clear_ready_drop", {31'd0, write_ready}, 32'd0);
    @(negedge clk);
    waitReady(600);
    checkOutput("clear_latency", cyc, t + 513);
    checkOutput("clear_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_ready", {31'd0, write_ready}, 32'd0);
      checkOutput("reset_we", {31'd0, mem_we}, 32'd0);
    end
    checkOutput("reset_mem_addr", {23'd0, mem_addr}, 32'd0);
    checkOutput("reset_font_addr", {22'd0, font_addr}, 32'd0);
    checkOutput("reset_wdata", {24'd0, mem_wdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", {31'd0, write_ready}, 32'd1);

    applyStimulus(8'h41, 9'h088, 1'b0, 1'b0);
    applyStimulus(8'hFF, 9'h1FC, 1'b0, 1'b0);
    applyClear();
    applyStimulus(8'h33, 9'h015, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) @(negedge clk);
    checkOutput("idle_ready", {31'd0, write_ready}, 32'd1);
    applyStimulus(8'h5A, 9'h100, 1'b0, 1'b1);
    applyStimulus(8'h20, 9'h0F9, 1'b0, 1'b0);
    applyStimulus(8'h8C, 9'h043, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    checkOutput("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
